// File: rtl/execute_stage_ctrl.sv
// Execute-stage sequencer: accepts decoded instructions, queues ALU results for the
// memory stage, turns control transfers into a fetch redirect and squashes the wrong path.
module execute_stage_ctrl #(
  parameter int N            = 32,
  parameter int DEPTH        = 2,
  parameter int SQUASH_DEPTH = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [6:0]       dec_opcode,
  input  logic [4:0]       dec_rd,
  input  logic [N-1:0]     dec_pc,
  input  logic [N-1:0]     dec_br_target,
  input  logic [N-1:0]     alu_result,
  input  logic             alu_br_taken,
  input  logic             mem_ready,
  output logic             ex_valid,
  output logic [6:0]       ex_opcode,
  output logic [4:0]       ex_rd,
  output logic [N-1:0]     ex_result,
  output logic             redirect_valid,
  output logic [N-1:0]     redirect_pc,
  output logic             squashing,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_QW = $clog2(DEPTH + 1);
  localparam int SQ_W = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic [6:0]   opcode;
    logic [4:0]   rd;
    logic [N-1:0] result;
  } entry_t;

  state_e            state_q, state_d;
  logic [SQ_W-1:0]   squash_q, squash_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_QW-1:0] count_q;
  logic              redirect_valid_q;
  logic [N-1:0]      redirect_pc_q;
  logic [CNT_W-1:0]  stall_cnt_q, redirect_cnt_q;
  entry_t            mem_q [DEPTH];

  logic              queue_full, queue_empty;
  logic              accept, pop, push;
  logic              redirect_d;
  logic [N-1:0]      redirect_target;
  entry_t            push_entry;
  entry_t            head;
  logic              is_jump, is_branch;

  assign queue_full  = (count_q == CNT_QW'(DEPTH));
  assign queue_empty = (count_q == '0);
  // Ready depends only on occupancy; a pop in the same cycle does not free a slot early.
  assign dec_ready   = !queue_full;
  assign accept      = dec_valid && dec_ready;
  assign pop         = !queue_empty && mem_ready;

  assign is_jump   = (dec_opcode == OPCODE_JAL) || (dec_opcode == OPCODE_JALR);
  assign is_branch = (dec_opcode == OPCODE_BRANCH);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    squash_d        = squash_q;
    push            = 1'b0;
    push_entry      = '0;
    redirect_d      = 1'b0;
    redirect_target = '0;

    if (flush) begin
      state_d  = ST_RUN;
      squash_d = '0;
    end else if (accept) begin
      unique case (state_q)
        ST_RUN: begin
          if (is_jump) begin
            push            = 1'b1;
            push_entry      = '{opcode: dec_opcode, rd: dec_rd, result: dec_pc + N'(4)};
            redirect_d      = 1'b1;
            redirect_target = alu_result;
          end else if (is_branch) begin
            if (alu_br_taken) begin
              redirect_d      = 1'b1;
              redirect_target = dec_br_target;
            end
          end else begin
            push       = 1'b1;
            push_entry = '{opcode: dec_opcode, rd: dec_rd, result: alu_result};
          end
          if (redirect_d && (SQUASH_DEPTH > 0)) begin
            state_d  = ST_SQUASH;
            squash_d = SQ_W'(SQUASH_DEPTH);
          end
        end
        ST_SQUASH: begin
          squash_d = squash_q - 1'b1;
          if (squash_q == SQ_W'(1)) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      squash_q         <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_cnt_q      <= '0;
      redirect_cnt_q   <= '0;
    end else begin
      state_q          <= state_d;
      squash_q         <= squash_d;
      redirect_valid_q <= redirect_d;
      if (redirect_d) redirect_pc_q <= redirect_target;

      if (redirect_d && (redirect_cnt_q != '1)) redirect_cnt_q <= redirect_cnt_q + 1'b1;
      if (dec_valid && !dec_ready && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        unique case ({push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // NOTE: the entry storage is deliberately not reset; occupancy lives in count_q and
  // the outputs are masked while the queue is empty, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head           = mem_q[rd_ptr_q];
  assign ex_valid       = !queue_empty;
  assign ex_opcode      = ex_valid ? head.opcode : '0;
  assign ex_rd          = ex_valid ? head.rd     : '0;
  assign ex_result      = ex_valid ? head.result : '0;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign squashing      = (state_q == ST_SQUASH);
  assign stall_cnt      = stall_cnt_q;
  assign redirect_cnt   = redirect_cnt_q;

endmodule

// File: tb/tb_execute_stage_ctrl.sv
// Bench for execute_stage_ctrl: directed scenarios followed by random traffic, all checked
// against a queue-based model of the queue/redirect/squash rules.
module tb_execute_stage_ctrl;

  localparam int N            = 32;
  localparam int DEPTH        = 2;
  localparam int SQUASH_DEPTH = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             dec_valid;
  logic             dec_ready;
  logic [6:0]       dec_opcode;
  logic [4:0]       dec_rd;
  logic [N-1:0]     dec_pc;
  logic [N-1:0]     dec_br_target;
  logic [N-1:0]     alu_result;
  logic             alu_br_taken;
  logic             mem_ready;
  logic             ex_valid;
  logic [6:0]       ex_opcode;
  logic [4:0]       ex_rd;
  logic [N-1:0]     ex_result;
  logic             redirect_valid;
  logic [N-1:0]     redirect_pc;
  logic             squashing;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  execute_stage_ctrl #(
    .N(N), .DEPTH(DEPTH), .SQUASH_DEPTH(SQUASH_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_rd(dec_rd), .dec_pc(dec_pc), .dec_br_target(dec_br_target),
    .alu_result(alu_result), .alu_br_taken(alu_br_taken), .mem_ready(mem_ready),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_result(ex_result),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .squashing(squashing),
    .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] res;
  } ent_t;

  ent_t        q[$];
  int          sq_left;
  int          m_stall;
  int          m_redir_cnt;
  bit          m_redir;
  logic [31:0] m_redir_pc;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sq_left     = 0;
    m_stall     = 0;
    m_redir_cnt = 0;
    m_redir     = 1'b0;
    m_redir_pc  = '0;
  endtask

  // Applies one clock edge worth of rules to the model, from the inputs now on the pins.
  task automatic model_step();
    bit          ready, acc, pop, redir;
    logic [31:0] tgt;
    ready = (q.size() < DEPTH);
    acc   = dec_valid && ready;
    pop   = (q.size() > 0) && mem_ready;
    redir = 1'b0;
    tgt   = '0;
    if (dec_valid && !ready && m_stall < CNT_MAX) m_stall++;
    if (flush) begin
      q.delete();
      sq_left = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (sq_left > 0) begin
          sq_left--;
        end else if (dec_opcode == OP_JAL || dec_opcode == OP_JALR) begin
          q.push_back('{dec_opcode, dec_rd, dec_pc + 32'd4});
          redir = 1'b1;
          tgt   = alu_result;
        end else if (dec_opcode == OP_BRANCH) begin
          if (alu_br_taken) begin
            redir = 1'b1;
            tgt   = dec_br_target;
          end
        end else begin
          q.push_back('{dec_opcode, dec_rd, alu_result});
        end
        if (redir) begin
          if (m_redir_cnt < CNT_MAX) m_redir_cnt++;
          sq_left = SQUASH_DEPTH;
        end
      end
    end
    m_redir = redir;
    if (redir) m_redir_pc = tgt;
  endtask

  task automatic compare_all();
    ent_t h;
    h = (q.size() > 0) ? q[0] : '{7'd0, 5'd0, 32'd0};
    check("dec_ready",      dec_ready,      q.size() < DEPTH);
    check("ex_valid",       ex_valid,       q.size() > 0);
    check("ex_opcode",      ex_opcode,      h.op);
    check("ex_rd",          ex_rd,          h.rd);
    check("ex_result",      ex_result,      h.res);
    check("redirect_valid", redirect_valid, m_redir);
    if (m_redir) check("redirect_pc", redirect_pc, m_redir_pc);
    check("squashing",      squashing,      sq_left > 0);
    check("stall_cnt",      stall_cnt,      m_stall);
    check("redirect_cnt",   redirect_cnt,   m_redir_cnt);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input logic [31:0] alu, input logic taken);
    dec_valid     = v;
    dec_opcode    = op;
    dec_rd        = rd;
    dec_pc        = pc;
    dec_br_target = tgt;
    alu_result    = alu;
    alu_br_taken  = taken;
  endtask

  logic [6:0] ops [6];

  initial begin
    ops = '{OP_ALU, OP_IMM, OP_LOAD, OP_BRANCH, OP_JAL, OP_JALR};
    rst_n     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 7'd0, 5'd0, '0, '0, '0, 1'b0);
    model_reset();

    // Reset state
    #12;
    check("rst_ex_valid",     ex_valid,       1'b0);
    check("rst_redirect",     redirect_valid, 1'b0);
    check("rst_squashing",    squashing,      1'b0);
    check("rst_stall_cnt",    stall_cnt,      '0);
    check("rst_redirect_cnt", redirect_cnt,   '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all();

    // Basic flow: one ADD in, one result out
    mem_ready = 1'b1;
    drive(1'b1, OP_ALU, 5'd5, 32'h0, 32'h0, 32'h7, 1'b0);
    step();
    check("basic_valid", ex_valid,  1'b1);
    check("basic_rd",    ex_rd,     5'd5);
    check("basic_res",   ex_result, 32'h7);
    dec_valid = 1'b0;
    step();
    check("basic_drained", ex_valid, 1'b0);

    // Backpressure: two accepts fill the queue, then two stalled cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OP_IMM, 5'(10 + i), 32'h0, 32'h0, 32'(32'hA0 + i), 1'b0);
      step();
    end
    check("bp_stall_cnt", stall_cnt, 4'd2);
    check("bp_ready",     dec_ready, 1'b0);
    check("bp_head0",     ex_rd,     5'd10);
    dec_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    check("bp_head1",     ex_rd,     5'd11);
    check("bp_head1_res", ex_result, 32'hA1);
    step();
    check("bp_empty",     ex_valid,  1'b0);

    // Taken branch: redirect, squash two, keep the third
    drive(1'b1, OP_BRANCH, 5'd0, 32'h80, 32'h100, 32'h0, 1'b1);
    step();
    check("br_redirect",     redirect_valid, 1'b1);
    check("br_redirect_pc",  redirect_pc,    32'h100);
    check("br_squashing",    squashing,      1'b1);
    check("br_redirect_cnt", redirect_cnt,   4'd1);
    check("br_not_queued",   ex_valid,       1'b0);
    drive(1'b1, OP_ALU, 5'd20, 32'h100, 32'h0, 32'h20, 1'b0);
    step();
    check("br_pulse_once",  redirect_valid, 1'b0);
    check("br_drop1",       ex_valid,       1'b0);
    drive(1'b1, OP_ALU, 5'd21, 32'h104, 32'h0, 32'h21, 1'b0);
    step();
    check("br_drop2",       ex_valid,       1'b0);
    check("br_squash_done", squashing,      1'b0);
    drive(1'b1, OP_ALU, 5'd22, 32'h108, 32'h0, 32'h22, 1'b0);
    step();
    check("br_kept_rd",     ex_rd,          5'd22);

    // JAL: link value queued, target redirected; a taken branch inside the window is ignored
    drive(1'b1, OP_JAL, 5'd1, 32'h40, 32'h0, 32'h80, 1'b0);
    step();
    check("jal_rd",           ex_rd,          5'd1);
    check("jal_link",         ex_result,      32'h44);
    check("jal_redirect",     redirect_valid, 1'b1);
    check("jal_redirect_pc",  redirect_pc,    32'h80);
    check("jal_redirect_cnt", redirect_cnt,   4'd2);
    drive(1'b1, OP_BRANCH, 5'd0, 32'h80, 32'h200, 32'h0, 1'b1);
    step();
    check("jal_sq_branch",     redirect_valid, 1'b0);
    check("jal_sq_branch_cnt", redirect_cnt,   4'd2);
    drive(1'b1, OP_ALU, 5'd9, 32'h84, 32'h0, 32'h9, 1'b0);
    step();
    check("jal_sq_end", squashing, 1'b0);

    // Flush priority: full queue and SQUASH active, flush alongside a taken branch
    mem_ready = 1'b0;
    drive(1'b1, OP_ALU, 5'd3, 32'h0, 32'h0, 32'h33, 1'b0);
    step();
    drive(1'b1, OP_JAL, 5'd4, 32'h10, 32'h0, 32'h300, 1'b0);
    step();
    check("fl_full",      dec_ready, 1'b0);
    check("fl_squashing", squashing, 1'b1);
    flush = 1'b1;
    drive(1'b1, OP_BRANCH, 5'd0, 32'h300, 32'h400, 32'h0, 1'b1);
    step();
    check("fl_ex_valid",     ex_valid,       1'b0);
    check("fl_squashing0",   squashing,      1'b0);
    check("fl_redirect",     redirect_valid, 1'b0);
    check("fl_redirect_cnt", redirect_cnt,   4'd3);
    drive(1'b1, OP_JAL, 5'd6, 32'h500, 32'h0, 32'h600, 1'b0);
    step();
    check("fl_acc_dropped", ex_valid,       1'b0);
    check("fl_acc_noredir", redirect_valid, 1'b0);
    flush = 1'b0;

    // Random traffic; the narrow counters saturate along the way
    for (int i = 0; i < 600; i++) begin
      flush     = ($urandom_range(0, 19) == 0);
      mem_ready = $urandom_range(0, 1);
      drive($urandom_range(0, 9) < 7, ops[$urandom_range(0, 5)], 5'($urandom),
            $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1'($urandom));
      step();
    end
    flush = 1'b0;

    // Async reset mid-stream, right after a redirect pulse with the queue occupied
    flush = 1'b1;
    dec_valid = 1'b0;
    step();
    flush = 1'b0;
    mem_ready = 1'b0;
    drive(1'b1, OP_JALR, 5'd7, 32'h700, 32'h0, 32'h900, 1'b0);
    step();
    check("ar_pre_valid",    ex_valid,       1'b1);
    check("ar_pre_redirect", redirect_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ex_valid",     ex_valid,       1'b0);
    check("ar_ex_result",    ex_result,      '0);
    check("ar_redirect",     redirect_valid, 1'b0);
    check("ar_squashing",    squashing,      1'b0);
    check("ar_stall_cnt",    stall_cnt,      '0);
    check("ar_redirect_cnt", redirect_cnt,   '0);
    check("ar_ready",        dec_ready,      1'b1);
    model_reset();
    dec_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(1'b1, OP_ALU, 5'd8, 32'h0, 32'h0, 32'h88, 1'b0);
    step();
    dec_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
